// File: rtl/impact_access_sequencer.sv
// Host-side access sequencer for the IMPACT SRAM head: stages host bytes into a
// 32-bit write word, runs timed precharge/access windows on the bank, and
// returns the selected byte of a read word. Single outstanding request.
module impact_access_sequencer #(
    parameter int unsigned PRE_CYCLES    = 2,
    parameter int unsigned ACCESS_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_bank,
    input  logic [9:0]  cmd_word,
    input  logic [1:0]  cmd_byte,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        sram_pre,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [1:0]  sram_bank,
    output logic [9:0]  sram_word,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned WORD_W = 10;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [LANE_W-1:0] COMMIT_LANE = LANE_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ      = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_write_q, is_write_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [BYTE_W-1:0]   rsp_data_q, rsp_data_d;
    logic                cmd_ready_q;
    logic                pre_q;
    logic                read_en_q;
    logic                write_en_q;
    logic                rsp_valid_q;
    logic                accept_c;
    logic [BYTE_W-1:0]   rd_byte_c;

    // Byte-lane select of the live bank read word.
    always_comb begin
        rd_byte_c = sram_rdata[7:0];
        case (lane_q)
            2'd0: rd_byte_c = sram_rdata[7:0];
            2'd1: rd_byte_c = sram_rdata[15:8];
            2'd2: rd_byte_c = sram_rdata[23:16];
            2'd3: rd_byte_c = sram_rdata[31:24];
            default: rd_byte_c = sram_rdata[7:0];
        endcase
    end

    // Next-state, counter, staging and latch logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        lane_d     = lane_q;
        hold_d     = hold_q;
        bank_d     = bank_q;
        word_d     = word_q;
        rsp_data_d = rsp_data_q;
        accept_c   = cmd_valid && cmd_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (cmd_write) begin
                        case (cmd_byte)
                            2'd0: hold_d[7:0]   = cmd_data;
                            2'd1: hold_d[15:8]  = cmd_data;
                            2'd2: hold_d[23:16] = cmd_data;
                            2'd3: hold_d[31:24] = cmd_data;
                            default: hold_d = hold_q;
                        endcase
                        // Only the lane-3 write commits the staged word.
                        if (cmd_byte == COMMIT_LANE) begin
                            bank_d     = cmd_bank;
                            word_d     = cmd_word;
                            is_write_d = 1'b1;
                            cnt_d      = PRE_LOAD;
                            state_d    = ST_PRECHARGE;
                        end
                    end else begin
                        bank_d     = cmd_bank;
                        word_d     = cmd_word;
                        lane_d     = cmd_byte;
                        is_write_d = 1'b0;
                        cnt_d      = PRE_LOAD;
                        state_d    = ST_PRECHARGE;
                    end
                end
            end
            ST_PRECHARGE: begin
                if (cnt_q == '0) begin
                    cnt_d   = ACC_LOAD;
                    state_d = is_write_q ? ST_WRITE : ST_READ;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READ: begin
                // Last read cycle: capture the requested byte for the response.
                if (cnt_q == '0) begin
                    rsp_data_d = rd_byte_c;
                    state_d    = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            lane_q      <= '0;
            hold_q      <= '0;
            bank_q      <= '0;
            word_q      <= '0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b1;
            pre_q       <= 1'b0;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            lane_q      <= lane_d;
            hold_q      <= hold_d;
            bank_q      <= bank_d;
            word_q      <= word_d;
            rsp_data_q  <= rsp_data_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            pre_q       <= (state_d == ST_PRECHARGE);
            read_en_q   <= (state_d == ST_READ);
            write_en_q  <= (state_d == ST_WRITE);
            rsp_valid_q <= (state_d == ST_RESPOND);
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign sram_pre      = pre_q;
    assign sram_read_en  = read_en_q;
    assign sram_write_en = write_en_q;
    assign sram_bank     = bank_q;
    assign sram_word     = word_q;
    assign sram_wdata    = hold_q;

endmodule

// File: tb/tb_impact_access_sequencer.sv
// Directed bench for impact_access_sequencer with PRE_CYCLES=2, ACCESS_CYCLES=3.
module tb_impact_access_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_bank;
    logic [9:0]  cmd_word;
    logic [1:0]  cmd_byte;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        sram_pre;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [1:0]  sram_bank;
    logic [9:0]  sram_word;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] model_word;

    int total;
    int bad;

    impact_access_sequencer #(.PRE_CYCLES(2), .ACCESS_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_bank(cmd_bank), .cmd_word(cmd_word), .cmd_byte(cmd_byte), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_pre(sram_pre), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_bank(sram_bank), .sram_word(sram_word), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    // Bank model: read word is only valid while read enable is high.
    assign sram_rdata = sram_read_en ? model_word : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command and hold it until accepted (bounded wait).
    task automatic issue(input logic wr, input logic [1:0] bank, input logic [9:0] word,
                         input logic [1:0] lane, input logic [7:0] data);
        int waited;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_bank = bank;
        cmd_word = word; cmd_byte = lane; cmd_data = data;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout: cmd_ready=%0b required 1 within 20 cycles", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", cmd_ready); end
            total++;
            if ({sram_pre, sram_read_en, sram_write_en} !== 3'b000) begin
                bad++; $display("FAIL reset_strobes: got %b want 000", {sram_pre, sram_read_en, sram_write_en});
            end
            total++;
            if (sram_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 00000000", sram_wdata); end
            total++;
            if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
                bad++; $display("FAIL reset_rsp: got valid=%0b data=%h want 0/00", rsp_valid, rsp_data);
            end
            total++;
            if (sram_bank !== 2'd0 || sram_word !== 10'd0) begin
                bad++; $display("FAIL reset_addr: got bank=%0d word=%h want 0/000", sram_bank, sram_word);
            end
        end
    endtask

    task automatic test_write_commit();
        issue(1'b1, 2'd1, 10'h2A5, 2'd0, 8'h11);
        @(negedge clk);
        total++;
        if (sram_wdata !== 32'h00000011 || cmd_ready !== 1'b1 || sram_pre !== 1'b0) begin
            bad++; $display("FAIL stage_lane0: got wdata=%h ready=%0b pre=%0b want 00000011/1/0", sram_wdata, cmd_ready, sram_pre);
        end
        issue(1'b1, 2'd1, 10'h2A5, 2'd1, 8'h22);
        issue(1'b1, 2'd1, 10'h2A5, 2'd2, 8'h33);
        @(negedge clk);
        total++;
        if (sram_wdata !== 32'h00332211 || cmd_ready !== 1'b1 || sram_bank !== 2'd0) begin
            bad++; $display("FAIL stage_lane2: got wdata=%h ready=%0b bank=%0d want 00332211/1/0", sram_wdata, cmd_ready, sram_bank);
        end
        issue(1'b1, 2'd1, 10'h2A5, 2'd3, 8'h44);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            total++;
            if (sram_pre !== (k <= 2) || sram_write_en !== (k >= 3 && k <= 5) || sram_read_en !== 1'b0) begin
                bad++; $display("FAIL commit_strobes c%0d: got pre=%0b we=%0b re=%0b", k, sram_pre, sram_write_en, sram_read_en);
            end
            total++;
            if (cmd_ready !== (k >= 6)) begin
                bad++; $display("FAIL commit_ready c%0d: got %0b want %0b", k, cmd_ready, (k >= 6));
            end
            total++;
            if (sram_bank !== 2'd1 || sram_word !== 10'h2A5 || sram_wdata !== 32'h44332211) begin
                bad++; $display("FAIL commit_addr c%0d: got bank=%0d word=%h wdata=%h want 1/2a5/44332211", k, sram_bank, sram_word, sram_wdata);
            end
        end
    endtask

    task automatic test_read();
        model_word = 32'hDEADBEEF;
        issue(1'b0, 2'd1, 10'h2A5, 2'd2, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (sram_pre !== (k <= 2) || sram_read_en !== (k >= 3 && k <= 5) || sram_write_en !== 1'b0) begin
                bad++; $display("FAIL read_strobes c%0d: got pre=%0b re=%0b we=%0b", k, sram_pre, sram_read_en, sram_write_en);
            end
            total++;
            if (rsp_valid !== (k == 6) || cmd_ready !== (k >= 7)) begin
                bad++; $display("FAIL read_handshake c%0d: got rsp_valid=%0b ready=%0b", k, rsp_valid, cmd_ready);
            end
            if (k >= 6) begin
                total++;
                if (rsp_data !== 8'hAD) begin bad++; $display("FAIL read_data c%0d: got %h want ad", k, rsp_data); end
            end
            total++;
            if (sram_bank !== 2'd1 || sram_word !== 10'h2A5) begin
                bad++; $display("FAIL read_addr c%0d: got bank=%0d word=%h want 1/2a5", k, sram_bank, sram_word);
            end
        end
    endtask

    task automatic test_lane3_only();
        issue(1'b1, 2'd2, 10'h155, 2'd3, 8'h99);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (sram_wdata !== 32'h99332211 || sram_bank !== 2'd2 || sram_word !== 10'h155) begin
                bad++; $display("FAIL lane3_word c%0d: got wdata=%h bank=%0d word=%h want 99332211/2/155", k, sram_wdata, sram_bank, sram_word);
            end
            total++;
            if (sram_pre !== (k <= 2) || sram_write_en !== (k >= 3 && k <= 5) || cmd_ready !== (k >= 6)) begin
                bad++; $display("FAIL lane3_timing c%0d: got pre=%0b we=%0b ready=%0b", k, sram_pre, sram_write_en, cmd_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        wr_l   [4];
        logic [1:0]  lane_l [4];
        int          exp_acc[4];
        int          acc    [4];
        logic [7:0]  exp_rsp[2];
        int idx, nrsp, npre, nwe, nre, overlap;
        logic took;
        wr_l[0] = 1'b0; lane_l[0] = 2'd0;
        wr_l[1] = 1'b1; lane_l[1] = 2'd3;
        wr_l[2] = 1'b0; lane_l[2] = 2'd3;
        wr_l[3] = 1'b1; lane_l[3] = 2'd3;
        exp_acc[0] = 0; exp_acc[1] = 7; exp_acc[2] = 13; exp_acc[3] = 20;
        exp_rsp[0] = 8'hEF; exp_rsp[1] = 8'hDE;
        for (int i = 0; i < 4; i++) acc[i] = -1;
        idx = 0; nrsp = 0; npre = 0; nwe = 0; nre = 0; overlap = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_write = wr_l[0]; cmd_byte = lane_l[0];
        cmd_bank = 2'd3; cmd_word = 10'h0F0; cmd_data = 8'hA0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            npre += int'(sram_pre); nwe += int'(sram_write_en); nre += int'(sram_read_en);
            if (int'(sram_pre) + int'(sram_write_en) + int'(sram_read_en) > 1) overlap++;
            if (rsp_valid) begin
                if (nrsp < 2) begin
                    total++;
                    if (rsp_data !== exp_rsp[nrsp]) begin
                        bad++; $display("FAIL b2b_rsp%0d: got %h want %h", nrsp, rsp_data, exp_rsp[nrsp]);
                    end
                end
                nrsp++;
            end
            took = cmd_valid && cmd_ready;
            if (took) acc[idx] = cyc;
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                if (idx < 4) begin
                    cmd_write = wr_l[idx]; cmd_byte = lane_l[idx];
                    cmd_data = 8'hA0 + 8'(idx);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (acc[i] !== exp_acc[i]) begin
                bad++; $display("FAIL b2b_accept%0d: got cycle %0d want %0d", i, acc[i], exp_acc[i]);
            end
        end
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap: got %0d overlapping cycles want 0", overlap); end
        total++;
        if (npre !== 8 || nwe !== 6 || nre !== 6 || nrsp !== 2) begin
            bad++; $display("FAIL b2b_counts: got pre=%0d we=%0d re=%0d rsp=%0d want 8/6/6/2", npre, nwe, nre, nrsp);
        end
        total++;
        if (sram_wdata !== 32'hA3332211) begin
            bad++; $display("FAIL b2b_wdata: got %h want a3332211", sram_wdata);
        end
    endtask

    task automatic test_reset_mid_write();
        int rsp_seen;
        rsp_seen = 0;
        issue(1'b1, 2'd0, 10'h001, 2'd0, 8'h5A);
        issue(1'b1, 2'd0, 10'h001, 2'd3, 8'h77);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (sram_write_en !== 1'b1) begin bad++; $display("FAIL mid_pre_reset_we: got %0b want 1", sram_write_en); end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({sram_pre, sram_read_en, sram_write_en} !== 3'b000 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset_drop: got strobes=%b ready=%0b want 000/1", {sram_pre, sram_read_en, sram_write_en}, cmd_ready);
        end
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            total++;
            if (cmd_ready !== 1'b1 || sram_wdata !== 32'h0 || {sram_pre, sram_read_en, sram_write_en} !== 3'b000) begin
                bad++; $display("FAIL mid_after: got ready=%0b wdata=%h strobes=%b want 1/00000000/000", cmd_ready, sram_wdata, {sram_pre, sram_read_en, sram_write_en});
            end
        end
        total++;
        if (rsp_seen !== 0) begin bad++; $display("FAIL mid_rsp: got %0d rsp_valid cycles want 0", rsp_seen); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_bank = 2'd0;
        cmd_word = 10'd0; cmd_byte = 2'd0; cmd_data = 8'd0; model_word = 32'h0;
        test_reset();
        test_write_commit();
        test_read();
        test_lane3_only();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/impact_access_sequencer.md
# impact_access_sequencer

Host-side access sequencer that sits directly upstream of the IMPACT SRAM head. It turns byte-wide host commands into properly phased SRAM bank cycles:
- it stages bytes into a 32-bit write word;
- it runs a precharge phase, then holds the read or write enable for a fixed window;
- it captures the 32-bit read word and returns the selected byte.

It replaces the raw GPIO-driven enables with a timed, single-outstanding-request handshake.

## Interface

Parameters:
- PRE_CYCLES, 2, cycles sram_pre is held high before each access (legal 1..255)
- ACCESS_CYCLES, 3, cycles sram_read_en / sram_write_en is held high (legal 1..255)

Ports:
- clk  in  1  single clock; all state is on its rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host request strobe
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write byte, 0 = read byte
- cmd_bank  in  2  bank select
- cmd_word  in  10  word address
- cmd_byte  in  2  byte lane; 0 = bits 7:0, 3 = bits 31:24
- cmd_data  in  8  write byte
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_data  out  8  read byte; holds its value until the next response
- sram_pre  out  1  precharge strobe to bank
- sram_read_en  out  1  bank read enable
- sram_write_en  out  1  bank write enable
- sram_bank  out  2  latched bank select
- sram_word  out  10  latched word address
- sram_wdata  out  32  staged write word
- sram_rdata  in  32  bank read word

## Operation

- States: IDLE, PRECHARGE, WRITE, READ, RESPOND.
  - One 8-bit down-counter times the PRECHARGE, WRITE and READ states.
- Write to byte lanes 0-2:
  - cmd_data is stored into the matching lane of the 32-bit hold register.
  - The FSM stays in IDLE and generates no SRAM activity.
  - cmd_ready stays high.
- Write to byte lane 3 (commit):
  - cmd_data is stored into lane 3 and cmd_bank/cmd_word are latched.
  - Sequence: IDLE → PRECHARGE → WRITE → IDLE.
  - The hold register is word-agnostic. Lanes not written since the last commit keep their previous values, and lanes staged under other addresses are still committed. Only the lane-3 command's bank/word are used.
  - The hold register is not cleared after a commit.
- Read:
  - cmd_bank, cmd_word and cmd_byte are latched.
  - Sequence: IDLE → PRECHARGE → READ → RESPOND → IDLE.
  - sram_rdata is sampled on the last READ cycle.
  - In RESPOND, rsp_data is the selected byte of the sampled word and rsp_valid = 1.
- Strobe rules:
  - sram_pre is high in PRECHARGE only.
  - sram_write_en is high in WRITE only; sram_read_en is high in READ only.
  - At most one of the three strobes is high in any cycle.
- Latched outputs:
  - sram_bank and sram_word change only on acceptance of a commit or a read.
  - sram_wdata reflects the hold register at all times, and so is stable throughout PRECHARGE and WRITE.
- cmd_valid while cmd_ready is low is ignored; it is not queued and not acknowledged.

## Timing

- Reset (rst low, asynchronous): enter IDLE and set:
  - cmd_ready = 1;
  - rsp_valid = 0, rsp_data = 0;
  - sram_pre = sram_read_en = sram_write_en = 0;
  - sram_bank = 0, sram_word = 0;
  - hold register = 0 (so sram_wdata = 0);
  - counter = 0.
- Reset mid-operation: strobes drop immediately, with no rsp_valid and no partial commit. Staged bytes are lost.
- Write commit accepted at cycle T:
  - sram_pre high T+1 .. T+PRE_CYCLES;
  - sram_write_en high T+PRE_CYCLES+1 .. T+PRE_CYCLES+ACCESS_CYCLES;
  - cmd_ready high again at T+PRE_CYCLES+ACCESS_CYCLES+1.
- Read accepted at cycle T:
  - same precharge window, then sram_read_en for ACCESS_CYCLES;
  - rsp_valid at T+PRE_CYCLES+ACCESS_CYCLES+1;
  - cmd_ready high at T+PRE_CYCLES+ACCESS_CYCLES+2.
- Staged byte write (lanes 0-2): the hold register updates at T+1, and a new command may be accepted at T+1.
- Back-to-back: a command presented in the cycle cmd_ready returns high is accepted in that cycle.
- No gap cycle is required between PRECHARGE and WRITE/READ, or between an access and IDLE.

## Test plan

All scenarios use PRE_CYCLES=2 and ACCESS_CYCLES=3.

- Reset released, idle for 5 cycles → cmd_ready=1, all strobes 0, sram_wdata=0, rsp_valid never asserts.
- Write bytes 0x11, 0x22, 0x33, 0x44 to lanes 0-3 of bank 1, word 0x2A5 → sram_wdata=0x44332211 at commit. Checks:
  - sram_pre is high for exactly 2 cycles, then sram_write_en for exactly 3;
  - sram_bank=1 and sram_word=0x2A5 throughout;
  - cmd_ready returns 6 cycles after the lane-3 accept.
- Read lane 2 of word 0x2A5 with the model returning 0xDEADBEEF → 2 cycles of pre, 3 cycles of read_en, then rsp_valid for one cycle with rsp_data=0xAD, 6 cycles after accept.
- Commit writing only lane 3 = 0x99 after the previous test → sram_wdata=0x99332211, confirming unwritten lanes persist.
- cmd_valid held high continuously with alternating reads and commits → each is accepted only when cmd_ready=1, none is lost or duplicated, and no two strobes ever overlap.
- rst pulsed low during WRITE cycle 2 → sram_write_en drops that cycle, no rsp_valid, and after release cmd_ready=1 with sram_wdata=0.
